// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - MEM-stage load/store unit with boundary-crossing split into two bus beats
module lsu_split #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic              req_write,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              dmem_valid,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_byte_en,
    output logic              dmem_wen,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_WAIT0  = 3'd2;
    localparam logic [2:0] S_ISSUE1 = 3'd3;
    localparam logic [2:0] S_WAIT1  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;
    logic              split_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;

    // Request decode, used only at acceptance
    logic [3:0]       req_nbytes;
    logic [2:0]       req_align_mask;
    logic [OFF_W-1:0] req_off;
    logic             req_illegal;
    logic             req_misaligned;
    logic             req_err;
    logic             req_split;

    assign req_nbytes     = 4'd1 << req_size;
    assign req_align_mask = 3'(req_nbytes - 4'd1);
    assign req_off        = req_addr[OFF_W-1:0];
    assign req_illegal    = req_nbytes > 4'(BYTES);
    assign req_misaligned = |(req_addr[2:0] & req_align_mask);
    assign req_err        = req_illegal || (!MISALIGN_EN && req_misaligned);
    assign req_split      = (5'(req_off) + 5'(req_nbytes)) > 5'(BYTES);

    // Lane placement: low half of the double-width shift is beat 0, high half is beat 1
    logic [3:0]          nbytes_q;
    logic [2*BYTES-1:0]  lane_en;
    logic [2*DATA_W-1:0] lane_data;
    logic                beat1;

    assign nbytes_q  = 4'd1 << size_q;
    assign lane_en   = (((2*BYTES)'(1) << nbytes_q) - (2*BYTES)'(1)) << off_q;
    assign lane_data = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign beat1     = (state == S_ISSUE1);

    assign req_ready    = (state == S_IDLE);
    assign dmem_valid   = (state == S_ISSUE0) || beat1;
    assign dmem_wen     = dmem_valid && write_q;
    assign dmem_addr    = (state == S_ISSUE0) ? base_q :
                          beat1 ? base_q + ADDR_W'(BYTES) : '0;
    assign dmem_byte_en = !dmem_valid ? '0 :
                          !write_q ? '1 :
                          beat1 ? lane_en[2*BYTES-1:BYTES] : lane_en[BYTES-1:0];
    assign dmem_wdata   = !dmem_wen ? '0 :
                          beat1 ? lane_data[2*DATA_W-1:DATA_W] : lane_data[DATA_W-1:0];

    // Load merge and extension
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] ext;
    logic              sign;

    assign raw = DATA_W'({(split_q ? hi_q : {DATA_W{1'b0}}), lo_q} >> {off_q, 3'b000});

    always_comb begin
        keep = '1;
        sign = 1'b0;
        case (size_q)
            2'd0: begin keep = DATA_W'(8'hFF);         sign = raw[7];  end
            2'd1: begin keep = DATA_W'(16'hFFFF);      sign = raw[15]; end
            2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sign = raw[31]; end
            default: begin keep = '1;                  sign = 1'b0;    end
        endcase
        ext = (raw & keep) | ({DATA_W{sign && !uns_q}} & ~keep);
    end

    assign resp_valid = (state == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !write_q && !err_q) ? ext : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            base_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base_q  <= req_addr & ~ADDR_W'(BYTES - 1);
                        off_q   <= req_off;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        write_q <= req_write;
                        split_q <= req_split;
                        err_q   <= req_err;
                        wdata_q <= req_wdata;
                        state   <= req_err ? S_RESP : S_ISSUE0;
                    end
                end
                S_ISSUE0: if (dmem_ready) state <= S_WAIT0;
                S_WAIT0: begin
                    if (dmem_rvalid) begin
                        lo_q  <= dmem_rdata;
                        state <= split_q ? S_ISSUE1 : S_RESP;
                    end
                end
                S_ISSUE1: if (dmem_ready) state <= S_WAIT1;
                S_WAIT1: begin
                    if (dmem_rvalid) begin
                        hi_q  <= dmem_rdata;
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// tb/tb_lsu_split.sv - directed bench for lsu_split (64-bit misaligned-capable and 32-bit strict instances)
module tb_lsu_split;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_unsigned, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        dmem_valid, dmem_ready, dmem_wen, dmem_rvalid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_byte_en;

    logic        s_req_valid, s_req_ready, s_req_unsigned, s_req_write;
    logic [31:0] s_req_addr, s_req_wdata;
    logic [1:0]  s_req_size;
    logic        s_resp_valid, s_resp_err;
    logic [31:0] s_resp_rdata;
    logic        s_dmem_valid, s_dmem_ready, s_dmem_wen, s_dmem_rvalid;
    logic [31:0] s_dmem_addr, s_dmem_wdata, s_dmem_rdata;
    logic [3:0]  s_dmem_byte_en;

    lsu_split #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write(req_write), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dmem_valid(dmem_valid), .dmem_ready(dmem_ready),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
        .dmem_wen(dmem_wen), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    lsu_split #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr),
        .req_wdata(s_req_wdata), .req_size(s_req_size), .req_unsigned(s_req_unsigned),
        .req_write(s_req_write), .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
        .resp_err(s_resp_err), .dmem_valid(s_dmem_valid), .dmem_ready(s_dmem_ready),
        .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata), .dmem_byte_en(s_dmem_byte_en),
        .dmem_wen(s_dmem_wen), .dmem_rvalid(s_dmem_rvalid), .dmem_rdata(s_dmem_rdata)
    );

    int n_pass = 0;
    int n_total = 0;

    int          beat_cnt, resp_cyc;
    logic [63:0] resp_d;
    logic        resp_e, stable_ok, busy_ok;
    logic [63:0] b_addr [2];
    logic [63:0] b_wdata [2];
    logic [7:0]  b_be [2];
    logic        b_wen [2];

    // Drives one request into the 64-bit unit and plays memory; results land in the module-level records
    task automatic do_access(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz,
                             input logic u, input logic w, input int stall,
                             input logic [63:0] r0, input logic [63:0] r1, input int abort_at);
        int stall_left;
        logic rv_next, held;
        logic [63:0] h_addr, h_wdata;
        logic [7:0] h_be;
        beat_cnt = 0; resp_cyc = -1; resp_d = '0; resp_e = 1'b0;
        stable_ok = 1'b1; busy_ok = 1'b1;
        stall_left = stall; rv_next = 1'b0; held = 1'b0;
        h_addr = '0; h_wdata = '0; h_be = '0;
        @(negedge clk);
        req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u; req_write = w;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == abort_at) begin
                dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
                return;
            end
            dmem_rvalid = rv_next;
            dmem_rdata  = !rv_next ? 64'h0 : (beat_cnt == 1) ? r0 : r1;
            rv_next = 1'b0;
            dmem_ready = 1'b0;
            if (req_ready) busy_ok = 1'b0;
            if (dmem_valid) begin
                if (held && (dmem_addr !== h_addr || dmem_wdata !== h_wdata || dmem_byte_en !== h_be))
                    stable_ok = 1'b0;
                if (stall_left > 0) begin
                    if (!held) begin
                        held = 1'b1; h_addr = dmem_addr; h_wdata = dmem_wdata; h_be = dmem_byte_en;
                    end
                    stall_left--;
                end else begin
                    held = 1'b0;
                    dmem_ready = 1'b1;
                    if (beat_cnt < 2) begin
                        b_addr[beat_cnt] = dmem_addr; b_wdata[beat_cnt] = dmem_wdata;
                        b_be[beat_cnt] = dmem_byte_en; b_wen[beat_cnt] = dmem_wen;
                    end
                    beat_cnt++;
                    rv_next = 1'b1;
                end
            end
            if (resp_valid) begin
                resp_cyc = k; resp_d = resp_rdata; resp_e = resp_err;
                break;
            end
        end
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic test_reset;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else n_pass++;
        n_total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) $display("FAIL reset_resp: got v=%b e=%b expected 0 0", resp_valid, resp_err); else n_pass++;
        n_total++; if (resp_rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", resp_rdata); else n_pass++;
        n_total++; if (dmem_valid !== 1'b0 || dmem_wen !== 1'b0) $display("FAIL reset_dmem_ctl: got v=%b w=%b expected 0 0", dmem_valid, dmem_wen); else n_pass++;
        n_total++; if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0 || dmem_byte_en !== 8'h0)
            $display("FAIL reset_dmem_bus: got a=%h d=%h be=%h expected 0 0 0", dmem_addr, dmem_wdata, dmem_byte_en); else n_pass++;
    endtask

    task automatic test_aligned_load;
        // off 3, bytes 3..6 of the word are 00 00 00 80 -> 0x80000000 sign-extended
        do_access(64'h1003, 64'h0, 2'd2, 1'b0, 1'b0, 0, 64'h0080_0000_0000_0000, 64'h0, 0);
        n_total++; if (beat_cnt !== 1) $display("FAIL ld_beats: got %0d expected 1", beat_cnt); else n_pass++;
        n_total++; if (b_addr[0] !== 64'h1000 || b_be[0] !== 8'hFF || b_wen[0] !== 1'b0)
            $display("FAIL ld_beat0: got a=%h be=%h w=%b expected 1000 ff 0", b_addr[0], b_be[0], b_wen[0]); else n_pass++;
        n_total++; if (resp_cyc !== 3) $display("FAIL ld_latency: got %0d expected 3", resp_cyc); else n_pass++;
        n_total++; if (resp_d !== 64'hFFFF_FFFF_8000_0000 || resp_e !== 1'b0)
            $display("FAIL ld_rdata: got %h e=%b expected ffffffff80000000 0", resp_d, resp_e); else n_pass++;
        n_total++; if (busy_ok !== 1'b1) $display("FAIL ld_busy: got %b expected 1", busy_ok); else n_pass++;
    endtask

    task automatic test_split_store;
        do_access(64'h2006, 64'hAABB_CCDD, 2'd2, 1'b0, 1'b1, 0, 64'h0, 64'h0, 0);
        n_total++; if (beat_cnt !== 2) $display("FAIL st_beats: got %0d expected 2", beat_cnt); else n_pass++;
        n_total++; if (b_addr[0] !== 64'h2000 || b_be[0] !== 8'hC0 || b_wdata[0] !== 64'hCCDD_0000_0000_0000 || b_wen[0] !== 1'b1)
            $display("FAIL st_beat0: got a=%h be=%h d=%h expected 2000 c0 ccdd000000000000", b_addr[0], b_be[0], b_wdata[0]); else n_pass++;
        n_total++; if (b_addr[1] !== 64'h2008 || b_be[1] !== 8'h03 || b_wdata[1] !== 64'hAABB || b_wen[1] !== 1'b1)
            $display("FAIL st_beat1: got a=%h be=%h d=%h expected 2008 03 aabb", b_addr[1], b_be[1], b_wdata[1]); else n_pass++;
        n_total++; if (resp_cyc !== 5 || resp_d !== 64'h0 || resp_e !== 1'b0)
            $display("FAIL st_resp: got cyc=%0d d=%h e=%b expected 5 0 0", resp_cyc, resp_d, resp_e); else n_pass++;
    endtask

    task automatic test_split_load;
        do_access(64'h2006, 64'h0, 2'd2, 1'b1, 1'b0, 0, 64'hCCDD_0000_0000_0000, 64'hAABB, 0);
        n_total++; if (resp_cyc !== 5 || resp_d !== 64'h0000_0000_AABB_CCDD)
            $display("FAIL sl_unsigned: got cyc=%0d d=%h expected 5 00000000aabbccdd", resp_cyc, resp_d); else n_pass++;
        n_total++; if (b_be[0] !== 8'hFF || b_be[1] !== 8'hFF) $display("FAIL sl_be: got %h %h expected ff ff", b_be[0], b_be[1]); else n_pass++;
        do_access(64'h2006, 64'h0, 2'd2, 1'b0, 1'b0, 0, 64'hCCDD_0000_0000_0000, 64'hAABB, 0);
        n_total++; if (resp_d !== 64'hFFFF_FFFF_AABB_CCDD) $display("FAIL sl_signed: got %h expected ffffffffaabbccdd", resp_d); else n_pass++;
        // address-space wrap on the second beat
        do_access(64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 2'd2, 1'b1, 1'b0, 0, 64'h2211_0000_0000_0000, 64'h4433, 0);
        n_total++; if (b_addr[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || b_addr[1] !== 64'h0)
            $display("FAIL wrap_addr: got %h %h expected fffffffffffffff8 0", b_addr[0], b_addr[1]); else n_pass++;
        n_total++; if (resp_d !== 64'h4433_2211) $display("FAIL wrap_rdata: got %h expected 44332211", resp_d); else n_pass++;
    endtask

    task automatic test_sizes;
        do_access(64'h3005, 64'h0, 2'd0, 1'b0, 1'b0, 0, 64'h0000_9A00_0000_0000, 64'h0, 0);
        n_total++; if (resp_d !== 64'hFFFF_FFFF_FFFF_FF9A) $display("FAIL byte_signed: got %h expected ffffffffffffff9a", resp_d); else n_pass++;
        do_access(64'h4000, 64'h0, 2'd3, 1'b0, 1'b0, 0, 64'h8123_4567_89AB_CDEF, 64'h0, 0);
        n_total++; if (resp_d !== 64'h8123_4567_89AB_CDEF || resp_cyc !== 3 || resp_e !== 1'b0)
            $display("FAIL double_load: got %h cyc=%0d e=%b expected 8123456789abcdef 3 0", resp_d, resp_cyc, resp_e); else n_pass++;
    endtask

    task automatic test_stall;
        do_access(64'h5001, 64'h1234, 2'd1, 1'b0, 1'b1, 3, 64'h0, 64'h0, 0);
        n_total++; if (stable_ok !== 1'b1) $display("FAIL stall_stable: got %b expected 1", stable_ok); else n_pass++;
        n_total++; if (b_addr[0] !== 64'h5000 || b_be[0] !== 8'h06 || b_wdata[0] !== 64'h12_3400)
            $display("FAIL stall_beat: got a=%h be=%h d=%h expected 5000 06 123400", b_addr[0], b_be[0], b_wdata[0]); else n_pass++;
        n_total++; if (resp_cyc !== 6) $display("FAIL stall_latency: got %0d expected 6", resp_cyc); else n_pass++;
    endtask

    task automatic test_spurious_rvalid;
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid || !req_ready) seen = 1'b1;
            dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_0001;
        end
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            if (resp_valid || !req_ready) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL spurious_rvalid: got activity=%b expected 0", seen); else n_pass++;
    endtask

    task automatic test_strict32;
        logic [31:0] addrs [2];
        logic [1:0]  sizes [2];
        int          cyc;
        logic        err, dv;
        addrs[0] = 32'h1002; sizes[0] = 2'd2;
        addrs[1] = 32'h2000; sizes[1] = 2'd3;
        for (int v = 0; v < 2; v++) begin
            cyc = -1; err = 1'b0; dv = 1'b0;
            @(negedge clk);
            s_req_addr = addrs[v]; s_req_size = sizes[v]; s_req_write = 1'b0; s_req_valid = 1'b1;
            @(posedge clk);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                s_req_valid = 1'b0;
                if (s_dmem_valid) dv = 1'b1;
                if (s_resp_valid && cyc < 0) begin cyc = k; err = s_resp_err; end
            end
            n_total++; if (cyc !== 1 || err !== 1'b1 || dv !== 1'b0)
                $display("FAIL strict32_err%0d: got cyc=%0d err=%b dmem=%b expected 1 1 0", v, cyc, err, dv); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        do_access(64'h2006, 64'h0, 2'd2, 1'b1, 1'b0, 0, 64'hCCDD_0000_0000_0000, 64'hAABB, 4);
        rst_n = 1'b0;
        #1;
        n_total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_valid !== 1'b0 || dmem_addr !== 64'h0 || dmem_byte_en !== 8'h0)
            $display("FAIL midreset_outputs: got rdy=%b rv=%b dv=%b a=%h be=%h expected 1 0 0 0 0",
                     req_ready, resp_valid, dmem_valid, dmem_addr, dmem_byte_en); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midreset_noresp: got %b expected 0", seen); else n_pass++;
        do_access(64'h1003, 64'h0, 2'd2, 1'b0, 1'b0, 0, 64'h0080_0000_0000_0000, 64'h0, 0);
        n_total++; if (resp_cyc !== 3 || resp_d !== 64'hFFFF_FFFF_8000_0000)
            $display("FAIL midreset_after: got cyc=%0d d=%h expected 3 ffffffff80000000", resp_cyc, resp_d); else n_pass++;
    endtask

    task automatic test_back_to_back;
        do_access(64'h6000, 64'h55, 2'd0, 1'b0, 1'b1, 0, 64'h0, 64'h0, 0);
        n_total++; if (resp_cyc !== 3 || b_be[0] !== 8'h01 || b_wdata[0] !== 64'h55)
            $display("FAIL b2b_first: got cyc=%0d be=%h d=%h expected 3 01 55", resp_cyc, b_be[0], b_wdata[0]); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL b2b_busy_in_resp: got %b expected 0", req_ready); else n_pass++;
        do_access(64'h6007, 64'h0, 2'd0, 1'b1, 1'b0, 0, 64'hF100_0000_0000_0000, 64'h0, 0);
        n_total++; if (resp_cyc !== 3 || resp_d !== 64'hF1)
            $display("FAIL b2b_second: got cyc=%0d d=%h expected 3 f1", resp_cyc, resp_d); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0; req_write = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        s_req_valid = 1'b0; s_req_addr = '0; s_req_wdata = '0; s_req_size = '0; s_req_unsigned = 1'b0; s_req_write = 1'b0;
        s_dmem_ready = 1'b0; s_dmem_rvalid = 1'b0; s_dmem_rdata = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_aligned_load;
        test_split_store;
        test_split_load;
        test_sizes;
        test_stall;
        test_spurious_rvalid;
        test_strict32;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
